// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the decode stage.
//   opcode_t      - RV32 major opcodes recognised by the core (plus HALT)
//   funct3_r_t    - R/I-type arithmetic funct3 encodings
//   funct3_b_t    - branch funct3 encodings
//   aluop_t       - ALU operation select (4 bits)
//   writesrc_t    - register write-back source select
//   ctrl_bundle_t - packed control bundle produced by decode
//   arith_aluop() - funct3/bit30 to ALU operation for R/I-type
package cpu_types_pkg;

   typedef enum logic [6:0] {
      RTYPE    = 7'b0110011,
      ITYPE    = 7'b0010011,
      ITYPE_LW = 7'b0000011,
      STYPE    = 7'b0100011,
      BTYPE    = 7'b1100011,
      JAL      = 7'b1101111,
      JALR     = 7'b1100111,
      LUI      = 7'b0110111,
      AUIPC    = 7'b0010111,
      LR_SC    = 7'b0101111,
      HALT     = 7'b1111111
   } opcode_t;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'd0,
      F3_SLL     = 3'd1,
      F3_SLT     = 3'd2,
      F3_SLTU    = 3'd3,
      F3_XOR     = 3'd4,
      F3_SRL_SRA = 3'd5,
      F3_OR      = 3'd6,
      F3_AND     = 3'd7
   } funct3_r_t;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'd0,
      F3_BNE  = 3'd1,
      F3_BLT  = 3'd4,
      F3_BGE  = 3'd5,
      F3_BLTU = 3'd6,
      F3_BGEU = 3'd7
   } funct3_b_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_SRA  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   typedef enum logic [1:0] {
      WS_ALU   = 2'b00,
      WS_LUI   = 2'b01,
      WS_PC4   = 2'b10,
      WS_AUIPC = 2'b11
   } writesrc_t;

   localparam logic [4:0] LR_F5 = 5'b00010;
   localparam logic [4:0] SC_F5 = 5'b00011;

   typedef struct packed {
      logic      alusrc;
      logic      memwr;
      logic      memread;
      logic      memtoreg;
      logic      regwr;
      logic      datomic;
      logic      is_lr;
      logic      is_sc;
      logic      is_halt;
      logic      illegal;
      aluop_t    aluop;
      writesrc_t writesrc;
   } ctrl_bundle_t;

   // Only R-type may select SUB via bit 30; shifts right use it for both.
   function automatic aluop_t arith_aluop(input funct3_r_t f3, input logic bit30,
                                          input logic is_reg);
      aluop_t op_v;
      case (f3)
         F3_ADD_SUB: op_v = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
         F3_SLL:     op_v = ALU_SLL;
         F3_SLT:     op_v = ALU_SLT;
         F3_SLTU:    op_v = ALU_SLTU;
         F3_XOR:     op_v = ALU_XOR;
         F3_SRL_SRA: op_v = bit30 ? ALU_SRA : ALU_SRL;
         F3_OR:      op_v = ALU_OR;
         F3_AND:     op_v = ALU_AND;
         default:    op_v = ALU_ADD;
      endcase
      return op_v;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side pipeline signals of the
// decode stage.
//   in_valid/in_ready/in_instr/in_pc    - fetch handshake
//   out_valid/out_ready/out_instr/out_pc - execute handshake
//   alusrc..writesrc                     - registered control bundle
// modport slave  : the decode stage itself
// modport master : the surrounding pipeline (fetch + execute)
interface decode_stage_if #(parameter int WORD_W = 32);
   import cpu_types_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_instr;
   logic [WORD_W-1:0] in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_instr;
   logic [WORD_W-1:0] out_pc;
   logic              alusrc, memwr, memread, memtoreg, regwr;
   logic              datomic, is_lr, is_sc, is_halt, illegal;
   aluop_t            aluop;
   writesrc_t         writesrc;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc,
             alusrc, memwr, memread, memtoreg, regwr,
             datomic, is_lr, is_sc, is_halt, illegal, aluop, writesrc
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc,
             alusrc, memwr, memread, memtoreg, regwr,
             datomic, is_lr, is_sc, is_halt, illegal, aluop, writesrc
   );
endinterface

// File: rtl/decode_logic.sv
// decode_logic: purely combinational instruction decoder.
//   instr - 32-bit instruction word
//   ctrl  - decoded control bundle
module decode_logic
   import cpu_types_pkg::*;
(
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl
);

   opcode_t    op_s;
   logic [4:0] f5_s;
   logic       unused_s;

   assign op_s     = opcode_t'(instr[6:0]);
   assign f5_s     = instr[31:27];
   assign unused_s = ^{instr[26:15], instr[11:7]};

   // Opcode-driven decode; defaults describe an immediate-operand no-op.
   always_comb begin
      ctrl          = '0;
      ctrl.alusrc   = 1'b1;
      ctrl.aluop    = ALU_ADD;
      ctrl.writesrc = WS_ALU;
      case (op_s)
         RTYPE: begin
            ctrl.alusrc = 1'b0;
            ctrl.regwr  = 1'b1;
            ctrl.aluop  = arith_aluop(funct3_r_t'(instr[14:12]), instr[30], 1'b1);
         end
         ITYPE: begin
            ctrl.regwr = 1'b1;
            ctrl.aluop = arith_aluop(funct3_r_t'(instr[14:12]), instr[30], 1'b0);
         end
         ITYPE_LW: begin
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwr    = 1'b1;
         end
         STYPE: ctrl.memwr = 1'b1;
         BTYPE: begin
            ctrl.alusrc = 1'b0;
            case (funct3_b_t'(instr[14:12]))
               F3_BLT, F3_BGE:   ctrl.aluop = ALU_SLT;
               F3_BLTU, F3_BGEU: ctrl.aluop = ALU_SLTU;
               default:          ctrl.aluop = ALU_SUB;
            endcase
         end
         JAL, JALR: begin
            ctrl.regwr    = 1'b1;
            ctrl.writesrc = WS_PC4;
         end
         LUI: begin
            ctrl.regwr    = 1'b1;
            ctrl.writesrc = WS_LUI;
         end
         AUIPC: begin
            ctrl.regwr    = 1'b1;
            ctrl.writesrc = WS_AUIPC;
         end
         LR_SC: begin
            ctrl.datomic  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwr    = 1'b1;
            ctrl.is_lr    = (f5_s == LR_F5);
            ctrl.is_sc    = (f5_s == SC_F5);
            ctrl.memread  = (f5_s == LR_F5);
            ctrl.memwr    = (f5_s == SC_F5);
         end
         HALT:    ctrl.is_halt = 1'b1;
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage_sva.sv
// decode_stage_sva: protocol checks on the decode stage's reservation port.
//   CLK, nRST            - clock and synchronous active-low reset
//   lr_commit, sc_commit - LR/SC commit strobes
module decode_stage_sva (
   input logic CLK,
   input logic nRST,
   input logic lr_commit,
   input logic sc_commit
);

   a_lr_sc_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
      !(lr_commit && sc_commit));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with backpressure, flush, sticky
// halt and the per-core LR/SC reservation.
//   CLK, nRST               - clock, synchronous active-low reset
//   bus                     - fetch/execute handshake + control bundle
//   flush                   - squash the output register
//   halted                  - sticky halt, cleared only by reset
//   lr_commit, sc_commit    - LR/SC completing, address on mem_addr
//   sc_success              - combinational, meaningful with sc_commit
//   snoop_valid, snoop_addr - remote write/invalidate
//   resv_valid, resv_owner  - reservation held / owning core id
module decode_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int RESV_LSB = 2,
   parameter int CPUID    = 0
) (
   input  logic              CLK,
   input  logic              nRST,
   decode_stage_if.slave     bus,
   input  logic              flush,
   output logic              halted,
   input  logic              lr_commit,
   input  logic              sc_commit,
   input  logic [WORD_W-1:0] mem_addr,
   output logic              sc_success,
   input  logic              snoop_valid,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              resv_valid,
   output logic [7:0]        resv_owner
);

   localparam logic [7:0] OWNER_ID = 8'(CPUID);

   ctrl_bundle_t             dec_s;
   ctrl_bundle_t             ctrl_r;
   logic                     out_valid_r;
   logic [WORD_W-1:0]        out_instr_r, out_pc_r;
   logic                     halted_r, halt_pending_r;
   logic                     resv_valid_r;
   logic [WORD_W-1:RESV_LSB] resv_addr_r;
   logic                     in_ready_s, xfer_s, snoop_match_s;
   logic                     unused_s;

   decode_logic u_decode (
      .instr (bus.in_instr[31:0]),
      .ctrl  (dec_s)
   );

   decode_stage_sva u_sva (
      .CLK       (CLK),
      .nRST      (nRST),
      .lr_commit (lr_commit),
      .sc_commit (sc_commit)
   );

   assign in_ready_s    = !halted_r && !halt_pending_r && (!out_valid_r || bus.out_ready);
   assign xfer_s        = bus.in_valid && in_ready_s;
   assign snoop_match_s = snoop_valid && (snoop_addr[WORD_W-1:RESV_LSB] == resv_addr_r);
   assign unused_s      = ^{mem_addr[RESV_LSB-1:0], snoop_addr[RESV_LSB-1:0]};

   // Output register, halt-pending and sticky halt.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         out_valid_r    <= 1'b0;
         ctrl_r         <= '0;
         out_instr_r    <= '0;
         out_pc_r       <= '0;
         halted_r       <= 1'b0;
         halt_pending_r <= 1'b0;
      end else begin
         // Flush beats a same-cycle transfer and cancels a queued HALT.
         if (flush) begin
            out_valid_r    <= 1'b0;
            halt_pending_r <= 1'b0;
         end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            ctrl_r      <= dec_s;
            out_instr_r <= bus.in_instr;
            out_pc_r    <= bus.in_pc;
            if (dec_s.is_halt) begin
               halt_pending_r <= 1'b1;
            end
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (out_valid_r && bus.out_ready && ctrl_r.is_halt && !flush) begin
            halted_r <= 1'b1;
         end
      end
   end

   // LR/SC reservation; a same-cycle LR overrides any snoop invalidation.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         resv_valid_r <= 1'b0;
         resv_addr_r  <= '0;
      end else if (lr_commit) begin
         resv_valid_r <= 1'b1;
         resv_addr_r  <= mem_addr[WORD_W-1:RESV_LSB];
      end else if (sc_commit || snoop_match_s) begin
         resv_valid_r <= 1'b0;
      end
   end

   assign sc_success    = sc_commit && resv_valid_r &&
                          (mem_addr[WORD_W-1:RESV_LSB] == resv_addr_r);
   assign resv_valid    = resv_valid_r;
   assign resv_owner    = OWNER_ID;
   assign halted        = halted_r;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_instr = out_instr_r;
   assign bus.out_pc    = out_pc_r;
   assign bus.alusrc    = ctrl_r.alusrc;
   assign bus.memwr     = ctrl_r.memwr;
   assign bus.memread   = ctrl_r.memread;
   assign bus.memtoreg  = ctrl_r.memtoreg;
   assign bus.regwr     = ctrl_r.regwr;
   assign bus.datomic   = ctrl_r.datomic;
   assign bus.is_lr     = ctrl_r.is_lr;
   assign bus.is_sc     = ctrl_r.is_sc;
   assign bus.is_halt   = ctrl_r.is_halt;
   assign bus.illegal   = ctrl_r.illegal;
   assign bus.aluop     = ctrl_r.aluop;
   assign bus.writesrc  = ctrl_r.writesrc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic for
// decode_stage, checked against a queue-based behavioural model.
module tb_decode_stage;
   import cpu_types_pkg::*;

   localparam int WORD_W   = 32;
   localparam int RESV_LSB = 2;
   localparam int CPUID    = 3;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              flush, halted, lr_commit, sc_commit, sc_success;
   logic              snoop_valid, resv_valid;
   logic [WORD_W-1:0] mem_addr, snoop_addr;
   logic [7:0]        resv_owner;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   decode_stage_if #(.WORD_W(WORD_W)) bus ();

   decode_stage #(.WORD_W(WORD_W), .RESV_LSB(RESV_LSB), .CPUID(CPUID)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .bus         (bus.slave),
      .flush       (flush),
      .halted      (halted),
      .lr_commit   (lr_commit),
      .sc_commit   (sc_commit),
      .mem_addr    (mem_addr),
      .sc_success  (sc_success),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .resv_valid  (resv_valid),
      .resv_owner  (resv_owner)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t      m_q[$];
   logic        m_halted;
   logic        m_rv;
   logic [29:0] m_ra;

   // Decode expectations written straight from the opcode rules.
   function automatic ctrl_bundle_t ref_decode(input logic [31:0] ins);
      ctrl_bundle_t e;
      aluop_t       base[8];
      logic [6:0]   op;
      logic [2:0]   f3;
      logic [4:0]   f5;
      base[0] = ALU_ADD; base[1] = ALU_SLL; base[2] = ALU_SLT;  base[3] = ALU_SLTU;
      base[4] = ALU_XOR; base[5] = ALU_SRL; base[6] = ALU_OR;   base[7] = ALU_AND;
      op = ins[6:0];
      f3 = ins[14:12];
      f5 = ins[31:27];
      e = '0;
      e.illegal  = !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                                7'h37, 7'h17, 7'h2F, 7'h7F});
      e.alusrc   = !(op == 7'h33 || op == 7'h63);
      e.datomic  = (op == 7'h2F);
      e.is_lr    = e.datomic && (f5 == 5'b00010);
      e.is_sc    = e.datomic && (f5 == 5'b00011);
      e.is_halt  = (op == 7'h7F);
      e.memwr    = (op == 7'h23) || e.is_sc;
      e.memread  = (op == 7'h03) || e.is_lr;
      e.memtoreg = (op == 7'h03) || e.datomic;
      e.regwr    = op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h2F};
      if (op == 7'h37)                       e.writesrc = WS_LUI;
      else if (op == 7'h6F || op == 7'h67)   e.writesrc = WS_PC4;
      else if (op == 7'h17)                  e.writesrc = WS_AUIPC;
      else                                   e.writesrc = WS_ALU;
      e.aluop = ALU_ADD;
      if (op == 7'h33 || op == 7'h13) begin
         e.aluop = base[f3];
         if (f3 == 3'd0 && op == 7'h33 && ins[30]) e.aluop = ALU_SUB;
         if (f3 == 3'd5 && ins[30])                e.aluop = ALU_SRA;
      end else if (op == 7'h63) begin
         if (f3 == 3'd4 || f3 == 3'd5)      e.aluop = ALU_SLT;
         else if (f3 == 3'd6 || f3 == 3'd7) e.aluop = ALU_SLTU;
         else                               e.aluop = ALU_SUB;
      end
      return e;
   endfunction

   function automatic ctrl_bundle_t observed();
      ctrl_bundle_t o;
      o.alusrc = bus.alusrc;   o.memwr   = bus.memwr;   o.memread = bus.memread;
      o.memtoreg = bus.memtoreg; o.regwr = bus.regwr;   o.datomic = bus.datomic;
      o.is_lr  = bus.is_lr;    o.is_sc   = bus.is_sc;   o.is_halt = bus.is_halt;
      o.illegal = bus.illegal; o.aluop   = bus.aluop;   o.writesrc = bus.writesrc;
      return o;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      lr_commit     = 1'b0;
      sc_commit     = 1'b0;
      mem_addr      = 32'h0;
      snoop_valid   = 1'b0;
      snoop_addr    = 32'h0;
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   // One clock: check combinational outputs, advance model, check registers.
   task automatic cyc();
      logic   front_halt, exp_ready, xfer, consumed, sc_exp;
      entry_t ent;
      #1;
      front_halt = (m_q.size() != 0) && (m_q[0].instr[6:0] == 7'h7F);
      exp_ready  = !m_halted && !front_halt && (m_q.size() == 0 || bus.out_ready);
      check_eq("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      if (sc_commit) begin
         sc_exp = m_rv && (mem_addr[31:2] == m_ra);
         check_eq("sc_success", 64'(sc_success), 64'(sc_exp));
      end
      xfer     = bus.in_valid && exp_ready;
      consumed = (m_q.size() != 0) && bus.out_ready;
      ent      = '{instr: bus.in_instr, pc: bus.in_pc};
      @(posedge CLK);
      if (!nRST) begin
         m_q.delete();
         m_halted = 1'b0;
         m_rv     = 1'b0;
         m_ra     = '0;
      end else begin
         if (consumed && !flush && front_halt) m_halted = 1'b1;
         if (flush) begin
            m_q.delete();
         end else begin
            if (consumed) void'(m_q.pop_front());
            if (xfer) m_q.push_back(ent);
         end
         if (lr_commit) begin
            m_rv = 1'b1;
            m_ra = mem_addr[31:2];
         end else if (sc_commit || (snoop_valid && snoop_addr[31:2] == m_ra)) begin
            m_rv = 1'b0;
         end
      end
      #1;
      check_eq("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check_eq("ctrl", 64'(observed()), 64'(ref_decode(m_q[0].instr)));
         check_eq("out_instr", 64'(bus.out_instr), 64'(m_q[0].instr));
         check_eq("out_pc", 64'(bus.out_pc), 64'(m_q[0].pc));
      end
      check_eq("halted", 64'(halted), 64'(m_halted));
      check_eq("resv_valid", 64'(resv_valid), 64'(m_rv));
      check_eq("resv_owner", 64'(resv_owner), 64'(CPUID));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops[11];
      logic [31:0] w;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h2F, 7'h0B};
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      if (w[6:0] == 7'h2F && $urandom_range(0, 2) != 0)
         w[31:27] = ($urandom_range(0, 1) != 0) ? 5'b00010 : 5'b00011;
      return w;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] tab[4];
      tab = '{32'h100, 32'h102, 32'h104, 32'h200};
      return tab[$urandom_range(0, 3)];
   endfunction

   initial begin
      int r;
      m_q.delete();
      m_halted = 1'b0;
      m_rv     = 1'b0;
      m_ra     = '0;
      nRST = 1'b0;
      idle();

      // Reset state.
      repeat (2) @(posedge CLK);
      #1;
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_ctrl", 64'(observed()), 64'd0);
      check_eq("rst_out_instr", 64'(bus.out_instr), 64'd0);
      check_eq("rst_out_pc", 64'(bus.out_pc), 64'd0);
      check_eq("rst_halted", 64'(halted), 64'd0);
      check_eq("rst_resv_valid", 64'(resv_valid), 64'd0);
      nRST = 1'b1;

      // ADD then SUB.
      send(32'h002081B3, 32'h0);
      cyc();
      check_eq("add_aluop", 64'(bus.aluop), 64'(ALU_ADD));
      check_eq("add_alusrc", 64'(bus.alusrc), 64'd0);
      check_eq("add_regwr", 64'(bus.regwr), 64'd1);
      send(32'h402081B3, 32'h4);
      cyc();
      check_eq("sub_aluop", 64'(bus.aluop), 64'(ALU_SUB));
      idle();
      cyc();

      // LW stalled by execute for three cycles.
      send(32'h00812283, 32'h8);
      cyc();
      send(32'h002081B3, 32'hC);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_eq("lw_memread", 64'(bus.memread), 64'd1);
         check_eq("lw_memtoreg", 64'(bus.memtoreg), 64'd1);
         check_eq("lw_alusrc", 64'(bus.alusrc), 64'd1);
         check_eq("lw_in_ready", 64'(bus.in_ready), 64'd0);
         check_eq("lw_pc_hold", 64'(bus.out_pc), 64'h8);
      end
      bus.out_ready = 1'b1;
      cyc();
      check_eq("lw_released", 64'(bus.out_pc), 64'hC);
      idle();
      cyc();

      // LR / SC success.
      send(32'h1000A2AF, 32'h10);
      cyc();
      check_eq("lr_is_lr", 64'(bus.is_lr), 64'd1);
      check_eq("lr_memread", 64'(bus.memread), 64'd1);
      idle();
      lr_commit = 1'b1; mem_addr = 32'h100;
      cyc();
      check_eq("lr_resv", 64'(resv_valid), 64'd1);
      idle();
      send(32'h1820A32F, 32'h14);
      cyc();
      check_eq("sc_is_sc", 64'(bus.is_sc), 64'd1);
      check_eq("sc_memwr", 64'(bus.memwr), 64'd1);
      idle();
      sc_commit = 1'b1; mem_addr = 32'h100;
      #1;
      check_eq("sc_pass", 64'(sc_success), 64'd1);
      cyc();
      check_eq("sc_clears_resv", 64'(resv_valid), 64'd0);

      // Snoop in the same word kills the reservation.
      idle();
      lr_commit = 1'b1; mem_addr = 32'h100;
      cyc();
      idle();
      snoop_valid = 1'b1; snoop_addr = 32'h102;
      cyc();
      check_eq("snoop_kill", 64'(resv_valid), 64'd0);
      idle();
      sc_commit = 1'b1; mem_addr = 32'h100;
      #1;
      check_eq("sc_after_snoop", 64'(sc_success), 64'd0);
      cyc();

      // LR and same-address snoop together: LR wins.
      idle();
      lr_commit = 1'b1; mem_addr = 32'h100; snoop_valid = 1'b1; snoop_addr = 32'h100;
      cyc();
      check_eq("lr_beats_snoop", 64'(resv_valid), 64'd1);

      // Flushed HALT does not halt.
      idle();
      bus.out_ready = 1'b0;
      send(32'hFFFFFFFF, 32'h20);
      cyc();
      check_eq("halt_bundle", 64'(bus.is_halt), 64'd1);
      bus.in_valid = 1'b0;
      #1;
      check_eq("halt_pend_ready", 64'(bus.in_ready), 64'd0);
      flush = 1'b1;
      cyc();
      idle();
      #1;
      check_eq("flush_halt_ready", 64'(bus.in_ready), 64'd1);
      check_eq("flush_halt_halted", 64'(halted), 64'd0);

      // Unknown opcode.
      send(32'h0000000B, 32'h24);
      cyc();
      check_eq("unk_illegal", 64'(bus.illegal), 64'd1);
      check_eq("unk_regwr", 64'(bus.regwr), 64'd0);
      idle();
      cyc();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         idle();
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_instr  = rand_instr();
         bus.in_pc     = $urandom;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 15) == 0);
         r = $urandom_range(0, 7);
         lr_commit     = (r == 0);
         sc_commit     = (r == 1);
         mem_addr      = rand_addr();
         snoop_valid   = ($urandom_range(0, 4) == 0);
         snoop_addr    = rand_addr();
         cyc();
      end

      // HALT consumed: sticky until reset.
      idle();
      cyc();
      send(32'hFFFFFFFF, 32'h30);
      cyc();
      send(32'h002081B3, 32'h34);
      cyc();
      cyc();
      check_eq("halt_sticky", 64'(halted), 64'd1);
      check_eq("halt_no_ready", 64'(bus.in_ready), 64'd0);
      nRST = 1'b0;
      cyc();
      nRST = 1'b1;
      idle();
      #1;
      check_eq("halt_reset", 64'(halted), 64'd0);
      check_eq("halt_reset_ready", 64'(bus.in_ready), 64'd1);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered decode stage of the pipelined core: accepts fetched instructions over a valid/ready handshake and decodes each into the control bundle.
- Holds the bundle in a single output register with backpressure and flush.
- Latches a sticky halt.
- Owns the per-core LR/SC reservation, including cross-core snoop invalidation, so the datapath gets an SC success bit.
- Sits between the fetch stage and the execute stage; one instance per core.

Parameters:
- WORD_W, 32, instruction/PC/address width (instruction decode uses bits [31:0]).
- RESV_LSB, 2, low address bits ignored by reservation compare (word granularity).
- CPUID, 0, core index, echoed on resv_owner for debug.

Ports:
- CLK in 1 clock, all state on rising edge.
- nRST in 1 synchronous active-low reset.
- in_valid in 1 fetch presents an instruction.
- in_ready out 1 stage can accept.
- in_instr in WORD_W instruction word.
- in_pc in WORD_W instruction PC.
- flush in 1 squash output register (branch/jump redirect).
- out_valid out 1 output register holds a live instruction.
- out_ready in 1 execute consumes the output register.
- out_instr, out_pc out WORD_W registered copies.
- alusrc, memwr, memread, memtoreg, regwr, datomic, is_lr, is_sc, is_halt, illegal out 1 registered control bits.
- aluop out 4 registered aluop_t.
- writesrc out 2 registered: 00 ALU/mem, 01 LUI imm, 10 PC+4, 11 AUIPC.
- halted out 1 sticky core halt.
- lr_commit in 1 LR completing memory access this cycle.
- sc_commit in 1 SC completing this cycle.
- mem_addr in WORD_W address of the committing LR/SC.
- sc_success out 1 combinational; valid only while sc_commit=1.
- snoop_valid in 1 other core's write or invalidate observed.
- snoop_addr in WORD_W snooped address.
- resv_valid out 1 reservation held.
- resv_owner out 8 = CPUID.

Behaviour:
- Reset (nRST=0 at edge): clears out_valid, all registered control outputs, out_instr, out_pc, halted, halt_pending, resv_valid, resv_addr.
- Handshake:
  - in_ready = !halted && !halt_pending && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - Latency is exactly 1 cycle to out_valid.
  - Output register contents stay stable while out_valid && !out_ready.
- Flush: out_valid goes to 0 next cycle and halt_pending is cleared. Flush has priority over a same-cycle transfer; the input is dropped.
- Decode (registered on transfer):
  - RTYPE/BTYPE: alusrc=0; all others alusrc=1.
  - RTYPE: funct3 selects op. ADD_SUB uses SUB iff instr[30]. SRL_SRA uses SRA iff instr[30].
  - ITYPE: same mapping, with SRAI iff instr[30].
  - ITYPE_LW, STYPE, JALR, AUIPC, LR_SC: ALU_ADD.
  - BTYPE: BLT/BGE use SLT; BLTU/BGEU use SLTU; otherwise SUB.
  - memwr = STYPE or (LR_SC with funct5=00011).
  - memread = ITYPE_LW or (LR_SC with funct5=00010).
  - memtoreg = ITYPE_LW or LR_SC.
  - is_lr and is_sc follow funct5; datomic = LR_SC.
  - regwr = 1 only for RTYPE, ITYPE, ITYPE_LW, JAL, JALR, LUI, AUIPC, LR_SC.
  - Unknown opcode: illegal=1, regwr=memwr=memread=0.
- Halt:
  - HALT opcode sets is_halt=1 in the bundle (all write enables 0) and sets halt_pending.
  - halted is set the cycle after out_valid && out_ready && is_halt, and stays set until reset.
  - A flushed HALT does not halt the core.
- Reservation:
  - lr_commit: resv_valid<=1, resv_addr<=mem_addr[WORD_W-1:RESV_LSB].
  - sc_success = sc_commit && resv_valid && address match.
  - Any sc_commit clears resv_valid, pass or fail.
  - snoop_valid with a matching address clears resv_valid.
- Simultaneous events:
  - lr_commit with a snoop to the same address in the same cycle: the LR wins (reservation set).
  - lr_commit and sc_commit together are illegal; assert in simulation.
- halted does not affect the reservation port.

Decomposition:
- cpu_types_pkg holds opcode_t, funct3 enums, aluop_t, a new writesrc_t, a new funct5 constants LR_F5=5'b00010 and SC_F5=5'b00011, and a packed ctrl_bundle_t struct.
- One combinational sub-module, decode_logic (instruction in, ctrl_bundle_t out), instantiated by decode_stage, which owns all state.

Test Plan:
- Reset then 0x002081B3 (add) with out_ready=1 -> next cycle out_valid=1, aluop=ALU_ADD, alusrc=0, regwr=1; then 0x402081B3 -> ALU_SUB.
- 0x00812283 (lw) held with out_ready=0 for 3 cycles -> memread=1, memtoreg=1, alusrc=1, in_ready=0, outputs stable; release -> consumed next cycle.
- 0x1000A2AF (lr.w) then lr_commit with mem_addr=0x100, then sc_commit with 0x1820A32F and mem_addr=0x100 -> is_lr/memread on first, is_sc/memwr on second, sc_success=1, resv_valid=0 after.
- LR at 0x100, snoop_valid with snoop_addr=0x102 -> resv_valid=0; following SC at 0x100 -> sc_success=0.
- 0xFFFFFFFF (HALT) accepted then flush -> halted stays 0, in_ready returns 1.
- HALT accepted and consumed -> halted=1 permanently, in_ready=0; nRST=0 for one edge clears it.
- Unknown opcode 0x0000000B -> illegal=1, regwr=0.
